// File: rtl/func_call_dispatcher.sv
// func_call_dispatcher
//   Shares INST_NUM identical HLS function instances among REQ_NUM requesters.
//   At most one call is accepted per cycle (round-robin over requesters) and
//   placed on the lowest-index idle instance. The instance's return value is
//   routed back to the requester that issued the call.
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   req_valid/ready  call handshake per requester (req_ready one-hot or zero)
//   req_args         packed arguments, requester r at [r*ARG_NUM*ARG_W +: ARG_NUM*ARG_W]
//   ret_valid/ready  return handshake per requester
//   ret_data         return value per requester, RET_DW bits each
//   inst_ap_start    HLS start per instance
//   inst_args        registered arguments per instance
//   inst_ap_ready    instance has taken its arguments
//   inst_ap_done     instance finished, inst_ap_return valid
module func_call_dispatcher #(
  parameter int REQ_NUM  = 4,
  parameter int INST_NUM = 2,
  parameter int ARG_NUM  = 8,
  parameter int ARG_W    = 32,
  parameter int RET_DW   = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [REQ_NUM-1:0]             req_valid,
  output logic [REQ_NUM-1:0]             req_ready,
  input  logic [REQ_NUM*ARG_NUM*ARG_W-1:0]  req_args,
  output logic [REQ_NUM-1:0]             ret_valid,
  output logic [REQ_NUM*RET_DW-1:0]      ret_data,
  input  logic [REQ_NUM-1:0]             ret_ready,
  output logic [INST_NUM-1:0]            inst_ap_start,
  output logic [INST_NUM*ARG_NUM*ARG_W-1:0] inst_args,
  input  logic [INST_NUM-1:0]            inst_ap_ready,
  input  logic [INST_NUM-1:0]            inst_ap_done,
  input  logic [INST_NUM*RET_DW-1:0]     inst_ap_return
);

  localparam int          AW    = ARG_NUM * ARG_W;
  localparam int          RW    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int unsigned REQ_U = REQ_NUM;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RETURN} state_t;

  state_t              state     [INST_NUM];
  state_t              state_nxt [INST_NUM];
  logic [RW-1:0]       owner     [INST_NUM];
  logic [RET_DW-1:0]   ret_reg   [INST_NUM];

  logic [INST_NUM-1:0] capture;
  logic [INST_NUM-1:0] inst_pick;
  logic                inst_found;
  logic [REQ_NUM-1:0]  busy;
  logic [REQ_NUM-1:0]  eligible;
  logic [RW-1:0]       rr_ptr;
  logic [RW-1:0]       winner;
  logic                win_found;
  logic                grant;
  int unsigned         scan_idx;

  // Requester arbitration and instance selection
  always_comb begin
    eligible   = req_valid & ~busy;
    win_found  = 1'b0;
    winner     = '0;
    scan_idx   = 0;
    inst_found = 1'b0;
    inst_pick  = '0;
    for (int unsigned j = 0; j < REQ_U; j++) begin
      scan_idx = (int'(rr_ptr) + j) % REQ_U;
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        winner    = RW'(scan_idx);
      end
    end
    // Only instances already IDLE at the start of the cycle are grantable,
    // so a RETURN->IDLE transition cannot be re-granted in the same cycle.
    for (int unsigned k = 0; k < INST_NUM; k++) begin
      if (!inst_found && state[k] == S_IDLE) begin
        inst_found   = 1'b1;
        inst_pick[k] = 1'b1;
      end
    end
    grant     = rstn & win_found & inst_found;
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Instance FSM next state
  always_comb begin
    for (int unsigned k = 0; k < INST_NUM; k++) begin
      state_nxt[k] = state[k];
      capture[k]   = 1'b0;
      case (state[k])
        S_IDLE:   if (grant && inst_pick[k]) state_nxt[k] = S_START;
        S_START:  if (inst_ap_ready[k]) begin
                    if (inst_ap_done[k]) begin
                      state_nxt[k] = S_RETURN;
                      capture[k]   = 1'b1;
                    end else begin
                      state_nxt[k] = S_BUSY;
                    end
                  end
        S_BUSY:   if (inst_ap_done[k]) begin
                    state_nxt[k] = S_RETURN;
                    capture[k]   = 1'b1;
                  end
        S_RETURN: if (ret_ready[owner[k]]) state_nxt[k] = S_IDLE;
        default:  state_nxt[k] = S_IDLE;
      endcase
    end
  end

  // Outputs: each requester owns at most one instance, so the return mux
  // never sees two instances driving the same requester.
  always_comb begin
    inst_ap_start = '0;
    ret_valid     = '0;
    ret_data      = '0;
    for (int unsigned k = 0; k < INST_NUM; k++) begin
      inst_ap_start[k] = (state[k] == S_START);
      if (state[k] == S_RETURN) begin
        ret_valid[owner[k]]                  = 1'b1;
        ret_data[owner[k]*RET_DW +: RET_DW] = ret_reg[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < INST_NUM; k++) state[k] <= S_IDLE;
    end else begin
      for (int unsigned k = 0; k < INST_NUM; k++) state[k] <= state_nxt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy      <= '0;
      rr_ptr    <= '0;
      inst_args <= '0;
      for (int unsigned k = 0; k < INST_NUM; k++) begin
        owner[k]   <= '0;
        ret_reg[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < INST_NUM; k++) begin
        if (grant && inst_pick[k]) begin
          owner[k]               <= winner;
          inst_args[k*AW +: AW]  <= req_args[winner*AW +: AW];
        end
        if (capture[k]) ret_reg[k] <= inst_ap_return[k*RET_DW +: RET_DW];
      end
      for (int unsigned r = 0; r < REQ_U; r++) begin
        if (req_ready[r])                    busy[r] <= 1'b1;
        else if (ret_valid[r] && ret_ready[r]) busy[r] <= 1'b0;
      end
      if (grant) rr_ptr <= (winner == RW'(REQ_NUM - 1)) ? '0 : winner + 1'b1;
    end
  end

  // ap_done outside BUSY (or START with ready) is a protocol error; it is ignored.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned k = 0; k < INST_NUM; k++) begin
        assert (!(inst_ap_done[k] &&
                  (state[k] == S_IDLE || (state[k] == S_START && !inst_ap_ready[k]))))
          else $error("func_call_dispatcher: ap_done on instance %0d without an accepted call", k);
      end
    end
  end

endmodule
